// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 1-write integer register file with a per-register
// scoreboard (busy bits) for a pipelined RISC-V core.
//   - Decode reads operands and busy flags combinationally.
//   - Issue marks the destination register pending.
//   - Writeback writes data and clears the pending flag.
//   - x0 is hard-wired to zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a writeback
// is forwarded to a read port that addresses the same register in the same
// cycle.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            writeEn,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] data_in,
    input  logic [AW-1:0]   readAddr1,
    input  logic [AW-1:0]   readAddr2,
    output logic [XLEN-1:0] data_out1,
    output logic [XLEN-1:0] data_out2,
    output logic            busy1,
    output logic            busy2,
    input  logic            issueEn,
    input  logic [AW-1:0]   issueAddr,
    input  logic            flush,
    output logic [AW:0]     nbusy
);

    localparam int NREGS = 1 << AW;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      nbusy_q;
    logic [AW:0]      nbusy_d;

    // Next busy vector: flush beats issue, and issue beats writeback. The
    // order matters because a new producer takes ownership of the register.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no
        // path can leave it unassigned and infer a latch.
        busy_d = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (flush)
                busy_d[i] = 1'b0;
            else if (issueEn && (issueAddr == AW'(i)))
                busy_d[i] = 1'b1;
            else if (writeEn && (addr == AW'(i)))
                busy_d[i] = 1'b0;
            else
                busy_d[i] = busy_q[i];
        end
    end

    // Popcount of the next busy vector. nbusy then moves on the same edge as
    // the busy bits themselves.
    always_comb begin
        nbusy_d = '0;
        for (int i = 0; i < NREGS; i++)
            nbusy_d = nbusy_d + (AW+1)'(busy_d[i]);
    end

    // Scoreboard state and busy count.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // flop samples its pre-edge value regardless of statement order.
        if (rst) begin
            busy_q  <= '0;
            nbusy_q <= '0;
        end else begin
            busy_q  <= busy_d;
            nbusy_q <= nbusy_d;
        end
    end

    // Register array. A write to x0 is dropped, so that entry stays zero.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is reset explicitly because every register must
        // read zero immediately after reset. This rules out a RAM macro, but
        // a 32-entry integer file is built from flops anyway.
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (writeEn && (addr != '0)) begin
            regs_q[addr] <= data_in;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forwarding read ports. A same-cycle writeback to the read address is
    // visible at once, and its busy flag reads clear unless a new producer
    // is issued to that register in the same cycle.
    always_comb begin
        fwd1 = writeEn && (addr != '0) && (addr == readAddr1);
        fwd2 = writeEn && (addr != '0) && (addr == readAddr2);

        if (readAddr1 == '0)
            data_out1 = '0;
        else if (fwd1)
            data_out1 = data_in;
        else
            data_out1 = regs_q[readAddr1];

        if (readAddr2 == '0)
            data_out2 = '0;
        else if (fwd2)
            data_out2 = data_in;
        else
            data_out2 = regs_q[readAddr2];

        busy1 = fwd1 ? (issueEn && (issueAddr == readAddr1)) : busy_q[readAddr1];
        busy2 = fwd2 ? (issueEn && (issueAddr == readAddr2)) : busy_q[readAddr2];
    end
`else
    // Plain read ports. They show the stored value and the stored busy bit,
    // so a writeback only becomes visible after the next edge.
    always_comb begin
        data_out1 = (readAddr1 == '0) ? '0 : regs_q[readAddr1];
        data_out2 = (readAddr2 == '0) ? '0 : regs_q[readAddr2];
        busy1     = busy_q[readAddr1];
        busy2     = busy_q[readAddr2];
    end
`endif

    assign nbusy = nbusy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb. A table of per-cycle vectors is applied in a loop,
// and each vector's expected outputs go through a scoreboard queue. Two
// hand-written sequences then cover same-cycle write/read visibility and an
// asynchronous mid-cycle reset. Build with REGFILE_BYPASS_EN to switch the
// expected forwarding behaviour.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic            writeEn;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data_in;
    logic [AW-1:0]   readAddr1;
    logic [AW-1:0]   readAddr2;
    logic [XLEN-1:0] data_out1;
    logic [XLEN-1:0] data_out2;
    logic            busy1;
    logic            busy2;
    logic            issueEn;
    logic [AW-1:0]   issueAddr;
    logic            flush;
    logic [AW:0]     nbusy;

    int total;
    int bad;

    typedef struct {
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   ra1;
        logic [AW-1:0]   ra2;
        logic            ie;
        logic [AW-1:0]   ia;
        logic            fl;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic            b1;
        logic            b2;
        logic [AW:0]     nb;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    regfile_sb #(.XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (writeEn),
        .addr      (addr),
        .data_in   (data_in),
        .readAddr1 (readAddr1),
        .readAddr2 (readAddr2),
        .data_out1 (data_out1),
        .data_out2 (data_out2),
        .busy1     (busy1),
        .busy2     (busy2),
        .issueEn   (issueEn),
        .issueAddr (issueAddr),
        .flush     (flush),
        .nbusy     (nbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input int wa, input logic [XLEN-1:0] wd,
                                input int ra1, input int ra2, input logic ie, input int ia,
                                input logic fl, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                                input logic b1, input logic b2, input int nb);
        vec_t v;
        v.we  = we;
        v.wa  = AW'(wa);
        v.wd  = wd;
        v.ra1 = AW'(ra1);
        v.ra2 = AW'(ra2);
        v.ie  = ie;
        v.ia  = AW'(ia);
        v.fl  = fl;
        v.d1  = d1;
        v.d2  = d2;
        v.b1  = b1;
        v.b2  = b2;
        v.nb  = (AW+1)'(nb);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        writeEn   = v.we;
        addr      = v.wa;
        data_in   = v.wd;
        readAddr1 = v.ra1;
        readAddr2 = v.ra2;
        issueEn   = v.ie;
        issueAddr = v.ia;
        flush     = v.fl;
    endtask

    task automatic idle_inputs();
        writeEn   = 1'b0;
        addr      = '0;
        data_in   = '0;
        readAddr1 = '0;
        readAddr2 = '0;
        issueEn   = 1'b0;
        issueAddr = '0;
        flush     = 1'b0;
    endtask

    initial begin
        vec_t e;
        logic [XLEN-1:0] exp_same;

        total = 0;
        bad   = 0;
        idle_inputs();
        rst = 1'b1;
        #12;
        rst = 1'b0;

        // Each row lists the inputs for one cycle and the outputs expected
        // before that cycle's edge. Reads never alias a same-cycle writeback
        // here, so the rows hold with and without forwarding.
        //            we wa wd            ra1 ra2 ie ia fl  d1            d2            b1 b2 nb
        vecs.push_back(mk(0, 0, 0,             0,  0, 0, 0, 0, 0,            0,            0, 0, 0)); // reset state
        vecs.push_back(mk(1, 5, 32'hDEADBEEF,  1,  0, 0, 0, 0, 0,            0,            0, 0, 0)); // write x5
        vecs.push_back(mk(1, 0, 32'h00001234,  5,  0, 0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 0)); // write x0 ignored
        vecs.push_back(mk(0, 0, 0,             0,  5, 1, 7, 0, 0,            32'hDEADBEEF, 0, 0, 0)); // x0 reads 0, issue x7
        vecs.push_back(mk(0, 0, 0,             7,  0, 0, 0, 0, 0,            0,            1, 0, 1)); // x7 busy
        vecs.push_back(mk(1, 7, 32'h00000055,  5,  0, 0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 1)); // writeback x7
        vecs.push_back(mk(0, 0, 0,             7,  0, 0, 0, 0, 32'h00000055, 0,            0, 0, 0)); // x7 clear, data
        vecs.push_back(mk(0, 0, 0,             9,  0, 1, 9, 0, 0,            0,            0, 0, 0)); // issue x9
        vecs.push_back(mk(1, 9, 32'h00000099,  7,  0, 1, 9, 0, 32'h00000055, 0,            0, 0, 1)); // issue+wb x9
        vecs.push_back(mk(0, 0, 0,             9,  7, 0, 0, 0, 32'h00000099, 32'h00000055, 1, 0, 1)); // x9 still busy
        vecs.push_back(mk(1, 9, 32'h0000009A,  5,  0, 0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 1)); // retire x9
        vecs.push_back(mk(0, 0, 0,             9,  0, 1, 1, 0, 32'h0000009A, 0,            0, 0, 0)); // issue x1
        vecs.push_back(mk(0, 0, 0,             1,  0, 1, 2, 0, 0,            0,            1, 0, 1)); // issue x2
        vecs.push_back(mk(0, 0, 0,             2,  0, 1, 3, 0, 0,            0,            1, 0, 2)); // issue x3
        vecs.push_back(mk(0, 0, 0,             3,  1, 1, 4, 0, 0,            0,            1, 1, 3)); // issue x4
        vecs.push_back(mk(1, 2, 32'h00000022,  4,  5, 0, 0, 1, 0,            32'hDEADBEEF, 1, 0, 4)); // flush + write x2
        vecs.push_back(mk(0, 0, 0,             2,  4, 0, 0, 0, 32'h00000022, 0,            0, 0, 0)); // all clear
        vecs.push_back(mk(0, 0, 0,             5,  7, 0, 0, 0, 32'hDEADBEEF, 32'h00000055, 0, 0, 0)); // contents kept
        vecs.push_back(mk(0, 0, 0,             0,  0, 1, 6, 0, 0,            0,            0, 0, 0)); // issue x6
        vecs.push_back(mk(0, 0, 0,             6,  0, 1, 6, 0, 0,            0,            1, 0, 1)); // WAW issue x6
        vecs.push_back(mk(0, 0, 0,             6,  0, 0, 0, 0, 0,            0,            1, 0, 1)); // x6 stays busy
        vecs.push_back(mk(1, 6, 32'h00000066,  5,  0, 0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 1)); // single wb x6
        vecs.push_back(mk(0, 0, 0,             6,  0, 0, 0, 0, 32'h00000066, 0,            0, 0, 0)); // x6 clear
        vecs.push_back(mk(0, 0, 0,             0,  0, 1, 8, 1, 0,            0,            0, 0, 0)); // flush beats issue
        vecs.push_back(mk(0, 0, 0,             8,  0, 0, 0, 0, 0,            0,            0, 0, 0)); // x8 not busy

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("row%0d data_out1", i), data_out1, e.d1);
            check($sformatf("row%0d data_out2", i), data_out2, e.d2);
            check($sformatf("row%0d busy1", i), XLEN'(busy1), XLEN'(e.b1));
            check($sformatf("row%0d busy2", i), XLEN'(busy2), XLEN'(e.b2));
            check($sformatf("row%0d nbusy", i), XLEN'(nbusy), XLEN'(e.nb));
        end

        // Same-cycle write and read of x3. Give x3 a known old value first.
        @(posedge clk);
        #1;
        idle_inputs();
        writeEn = 1'b1;
        addr    = AW'(3);
        data_in = 32'h00000033;
        @(posedge clk);
        #1;
        data_in   = 32'hA5A5A5A5;
        readAddr2 = AW'(3);
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'h00000033;
`endif
        @(negedge clk);
        check("same-cycle data_out2", data_out2, exp_same);
        check("same-cycle busy2", XLEN'(busy2), '0);
        @(posedge clk);
        #1;
        writeEn = 1'b0;
        @(negedge clk);
        check("next-cycle data_out2", data_out2, 32'hA5A5A5A5);

        // Asynchronous reset in the middle of a cycle, with no clock edge
        // between the assertion and the checks.
        @(posedge clk);
        #1;
        issueEn   = 1'b1;
        issueAddr = AW'(10);
        @(posedge clk);
        #1;
        issueEn   = 1'b0;
        readAddr1 = AW'(3);
        readAddr2 = AW'(10);
        @(negedge clk);
        check("pre-reset busy2", XLEN'(busy2), 32'd1);
        check("pre-reset nbusy", XLEN'(nbusy), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst data_out1", data_out1, '0);
        check("async rst busy2", XLEN'(busy2), '0);
        check("async rst nbusy", XLEN'(nbusy), '0);
        #1;
        rst = 1'b0;
        writeEn = 1'b1;
        addr    = AW'(3);
        data_in = 32'h0BADF00D;
        @(posedge clk);
        #1;
        writeEn = 1'b0;
        @(negedge clk);
        check("post-reset write", data_out1, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
